// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO byte offsets, TX_STATUS
// bit positions and the address-decode select type.
package dmem_pkg;

  localparam logic [15:0] TX_DATA_OFS   = 16'h0000;
  localparam logic [15:0] TX_STATUS_OFS = 16'h0004;
  localparam logic [15:0] CYCLE_OFS     = 16'h0008;
  localparam logic [15:0] DROP_CNT_OFS  = 16'h000C;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_MMIO
  } sel_e;

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data port plus TX stream bundle; the responder takes the slave side.
interface dmem_responder_if;

  logic [31:0] dAddr;
  logic [31:0] dataOut;
  logic        DRAMwe;
  logic [31:0] dataIn;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  modport master (
    output dAddr, dataOut, DRAMwe, tx_ready,
    input  dataIn, tx_valid, tx_data
  );

  modport slave (
    input  dAddr, dataOut, DRAMwe, tx_ready,
    output dataIn, tx_valid, tx_data
  );

endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// Parameterised synchronous FIFO with async active-low reset; head reads 0
// when empty. A push while full is accepted only if a pop happens on that edge.
module tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO window (TX FIFO, drop counter,
// cycle counter). CYCLE is only built when DMEM_CYCLE_COUNTER_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] MMIO_HI    = 16'hFFFF
) (
  input logic              clk,
  input logic              reset,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [DEPTH];
  logic [AW-1:0] word_idx;
  logic [15:0]   reg_ofs;
  sel_e          sel;
  logic          addr_unused;

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          drop;
  logic          drop_clr;
  logic [31:0]   drop_cnt;
  logic [31:0]   cycle_val;
  logic [31:0]   status;
  logic [31:0]   rd_data;

  assign word_idx    = bus.dAddr[AW+1:2];
  assign reg_ofs     = {bus.dAddr[15:2], 2'b00};
  assign addr_unused = ^bus.dAddr[1:0];

  // RAM wins over MMIO should a parameter choice make the two ranges overlap
  always_comb begin
    sel = SEL_NONE;
    if ({2'b00, bus.dAddr[31:2]} < 32'(DEPTH))
      sel = SEL_RAM;
    else if (bus.dAddr[31:16] == MMIO_HI)
      sel = SEL_MMIO;
  end

  assign push     = bus.DRAMwe && (sel == SEL_MMIO) && (reg_ofs == TX_DATA_OFS);
  assign drop_clr = bus.DRAMwe && (sel == SEL_MMIO) && (reg_ofs == DROP_CNT_OFS);
  assign pop      = !fifo_empty && bus.tx_ready;
  assign drop     = push && fifo_full && !pop;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (bus.dataOut),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (bus.tx_data)
  );

  assign bus.tx_valid = !fifo_empty;

  always_ff @(posedge clk) begin
    if (bus.DRAMwe && (sel == SEL_RAM)) ram[word_idx] <= bus.dataOut;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      drop_cnt <= '0;
    else if (drop_clr)
      drop_cnt <= '0;
    else if (drop && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 1'b1;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_cnt <= '0;
    else        cycle_cnt <= cycle_cnt + 1'b1;
  end

  assign cycle_val = cycle_cnt;
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    status                      = '0;
    status[ST_FULL]             = fifo_full;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_COUNT_LSB +: 8]   = 8'(fifo_count);
  end

  always_comb begin
    rd_data = '0;
    unique case (sel)
      SEL_RAM:  rd_data = ram[word_idx];
      SEL_MMIO: begin
        case (reg_ofs)
          TX_STATUS_OFS: rd_data = status;
          CYCLE_OFS:     rd_data = cycle_val;
          DROP_CNT_OFS:  rd_data = drop_cnt;
          default:       rd_data = '0;
        endcase
      end
      default:  rd_data = '0;
    endcase
  end

  assign bus.dataIn = rd_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset/counter
// sequence, then random traffic against a queue-based reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH      = 1024;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned AW         = $clog2(DEPTH);
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH      (DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMIO_HI    (16'hFFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_ram [DEPTH];
  logic [31:0] m_q [$];
  logic [31:0] m_drop;
  logic [31:0] m_cycle;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    bit          rdy;
    logic [31:0] din;
    bit          v;
    logic [31:0] td;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input bit we, input logic [31:0] a, input logic [31:0] d,
                              input bit rdy, input logic [31:0] din, input bit v,
                              input logic [31:0] td);
    vec_t r;
    r.we = we; r.a = a; r.d = d; r.rdy = rdy; r.din = din; r.v = v; r.td = td;
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a);
    logic [31:0] st;
    if (a[31:2] < DEPTH) return m_ram[a[AW+1:2]];
    if (a[31:16] == 16'hFFFF) begin
      case (a[15:0] & 16'hFFFC)
        16'h0004: begin
          st        = '0;
          st[0]     = (m_q.size() == FIFO_DEPTH);
          st[1]     = (m_q.size() == 0);
          st[15:8]  = 8'(m_q.size());
          return st;
        end
        16'h0008: return CYC_EN ? m_cycle : 32'h0;
        16'h000C: return m_drop;
        default:  return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drop  = '0;
    m_cycle = '0;
  endtask

  // Model of one rising edge with the given CPU/stream inputs
  task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] d,
                            input bit rdy);
    bit pop;
    bit push;
    pop  = (m_q.size() != 0) && rdy;
    push = 1'b0;
    if (we) begin
      if (a[31:2] < DEPTH) m_ram[a[AW+1:2]] = d;
      else if (a[31:16] == 16'hFFFF) begin
        if ((a[15:0] & 16'hFFFC) == 16'h0000) push = 1'b1;
        if ((a[15:0] & 16'hFFFC) == 16'h000C) m_drop = '0;
      end
    end
    if (push && (m_q.size() == FIFO_DEPTH) && !pop) begin
      if (m_drop != 32'hFFFF_FFFF) m_drop++;
      push = 1'b0;
    end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    m_cycle++;
  endtask

  // Drive at the falling edge, compare mid-low-phase, then take the rising edge
  task automatic step(input vec_t v, input bit chk_model, input bit chk_tbl, input string nm);
    bus.DRAMwe   = v.we;
    bus.dAddr    = v.a;
    bus.dataOut  = v.d;
    bus.tx_ready = v.rdy;
    #2;
    if (chk_model) begin
      check({nm, "_dataIn_mdl"},   bus.dataIn,          m_load(v.a));
      check({nm, "_tx_valid_mdl"}, 32'(bus.tx_valid),   32'(m_q.size() != 0));
      check({nm, "_tx_data_mdl"},  bus.tx_data,         (m_q.size() != 0) ? m_q[0] : 32'h0);
    end
    if (chk_tbl) begin
      check({nm, "_dataIn"},   bus.dataIn,        v.din);
      check({nm, "_tx_valid"}, 32'(bus.tx_valid), 32'(v.v));
      check({nm, "_tx_data"},  bus.tx_data,       v.td);
    end
    @(posedge clk);
    model_edge(v.we, v.a, v.d, v.rdy);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;

    bus.DRAMwe = 1'b0; bus.dAddr = '0; bus.dataOut = '0; bus.tx_ready = 1'b0;
    model_reset();

    // Reset state
    bus.dAddr = 32'hFFFF_0004;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data",  bus.tx_data,       32'h0);
    check("rst_status",   bus.dataIn,        32'h0000_0002);
    @(negedge clk);
    reset = 1'b1;

    // Give every RAM word a known value
    for (int unsigned i = 0; i < DEPTH; i++)
      step(mk(1'b1, i * 4, 32'hA5A5_0000 + i, 1'b0, '0, 1'b0, '0), 1'b0, 1'b0, "fill");

    // Directed vectors
    tbl.push_back(mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'hA5A5_0004, 0, 0));
    tbl.push_back(mk(0, 32'h0000_0010, 0,             0, 32'hDEAD_BEEF, 0, 0));
    tbl.push_back(mk(1, 32'h8000_0000, 32'h1234_5678, 0, 32'h0,         0, 0));
    tbl.push_back(mk(0, 32'h8000_0000, 0,             0, 32'h0,         0, 0));
    tbl.push_back(mk(0, 32'h0000_0000, 0,             0, 32'hA5A5_0000, 0, 0));
    tbl.push_back(mk(1, 32'hFFFF_0000, 32'h1,         0, 32'h0,         0, 0));
    tbl.push_back(mk(1, 32'hFFFF_0000, 32'h2,         0, 32'h0,         1, 1));
    tbl.push_back(mk(1, 32'hFFFF_0000, 32'h3,         0, 32'h0,         1, 1));
    tbl.push_back(mk(0, 32'hFFFF_0004, 0,             0, 32'h0000_0300, 1, 1));
    tbl.push_back(mk(0, 32'h0000_0000, 0,             1, 32'hA5A5_0000, 1, 1));
    tbl.push_back(mk(0, 32'h0000_0000, 0,             1, 32'hA5A5_0000, 1, 2));
    tbl.push_back(mk(0, 32'h0000_0000, 0,             1, 32'hA5A5_0000, 1, 3));
    tbl.push_back(mk(0, 32'hFFFF_0004, 0,             0, 32'h0000_0002, 0, 0));
    for (int unsigned k = 0; k < 10; k++)
      tbl.push_back(mk(1, 32'hFFFF_0000, 32'h100 + k, 0, 32'h0, k != 0, (k != 0) ? 32'h100 : 32'h0));
    tbl.push_back(mk(0, 32'hFFFF_000C, 0,             0, 32'h2,         1, 32'h100));
    tbl.push_back(mk(0, 32'hFFFF_0004, 0,             0, 32'h0000_0801, 1, 32'h100));
    tbl.push_back(mk(1, 32'hFFFF_0000, 32'h200,       1, 32'h0,         1, 32'h100));
    tbl.push_back(mk(0, 32'hFFFF_0004, 0,             0, 32'h0000_0801, 1, 32'h101));
    tbl.push_back(mk(0, 32'hFFFF_000C, 0,             0, 32'h2,         1, 32'h101));
    tbl.push_back(mk(1, 32'hFFFF_000C, 32'h55,        0, 32'h2,         1, 32'h101));
    tbl.push_back(mk(0, 32'hFFFF_000C, 0,             0, 32'h0,         1, 32'h101));
    for (int unsigned k = 0; k < 7; k++)
      tbl.push_back(mk(0, 32'h0000_0000, 0, 1, 32'hA5A5_0000, 1, 32'h101 + k));
    tbl.push_back(mk(0, 32'h0000_0000, 0,             1, 32'hA5A5_0000, 1, 32'h200));
    tbl.push_back(mk(0, 32'hFFFF_0004, 0,             0, 32'h0000_0002, 0, 0));
    tbl.push_back(mk(1, 32'hFFFF_0010, 32'hFFFF,      0, 32'h0,         0, 0));
    tbl.push_back(mk(0, 32'hFFFF_0010, 0,             0, 32'h0,         0, 0));
    tbl.push_back(mk(0, 32'h0000_0FFC, 0,             0, 32'hA5A5_03FF, 0, 0));
    tbl.push_back(mk(0, 32'h0000_1000, 0,             0, 32'h0,         0, 0));

    foreach (tbl[i])
      step(tbl[i], 1'b1, 1'b1, $sformatf("vec%0d", i));

    // Reset mid-stream: stream must drop without a clock edge
    for (int unsigned k = 0; k < 3; k++)
      step(mk(1, 32'hFFFF_0000, 32'h300 + k, 0, 0, 0, 0), 1'b1, 1'b0, "pre_rst");
    reset = 1'b0;
    #1;
    check("midrst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("midrst_tx_data",  bus.tx_data,       32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    step(mk(0, 32'hFFFF_0008, 0, 0, 32'h0, 0, 0), 1'b1, 1'b1, "cycle0");
    for (int unsigned k = 0; k < 4; k++)
      step(mk(0, 32'h0000_0000, 0, 0, 32'hA5A5_0000, 0, 0), 1'b1, 1'b0, "idle");
    step(mk(0, 32'hFFFF_0008, 0, 0, CYC_EN ? 32'h5 : 32'h0, 0, 0), 1'b1, 1'b1, "cycle5");
    step(mk(1, 32'hFFFF_0008, 32'h1234, 0, CYC_EN ? 32'h6 : 32'h0, 0, 0), 1'b1, 1'b1, "cycle_st");
    step(mk(0, 32'hFFFF_0008, 0, 0, CYC_EN ? 32'h7 : 32'h0, 0, 0), 1'b1, 1'b1, "cycle7");

    // Random traffic against the model
    for (int unsigned n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)
        a = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(0, 3);
      else if (r < 8)
        a = 32'hFFFF_0000 | ($urandom_range(0, 5) * 4) | $urandom_range(0, 3);
      else if (r == 8)
        a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFF);
      else
        a = 32'h0000_1000 + ($urandom_range(0, 255) * 4);
      step(mk($urandom_range(0, 1), a, $urandom, $urandom_range(0, 3) != 0, 0, 0, 0),
           1'b1, 1'b0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle CPU's data port. It answers `dAddr`/`dataOut`/`DRAMwe` with a word RAM and a small memory-mapped I/O window. The window contains a transmit FIFO drained over a valid/ready stream, a drop counter and a free-running cycle counter. It sits beside the instruction memory at the top level and drives the CPU's `dataIn`.

## Interface

**Parameters**
- `DEPTH`, 1024: RAM size in 32-bit words; must be a power of two.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, at most 128.
- `MMIO_HI`, 16'hFFFF: `dAddr[31:16]` value that selects the MMIO window.

**Ports** (reset is asynchronous and active-low)
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low (0 = in reset).
- `dAddr` in 32: byte address from the CPU; `dAddr[1:0]` ignored.
- `dataOut` in 32: CPU store data.
- `DRAMwe` in 1: store strobe, sampled at the rising edge.
- `dataIn` out 32: load data to the CPU; combinational from `dAddr`.
- `tx_valid` out 1: FIFO head is valid.
- `tx_data` out 32: FIFO head word.
- `tx_ready` in 1: downstream accepts the head.

## Operation

**Address decode**
- RAM is selected when `dAddr[31:2] < DEPTH`. It uses word index `dAddr[log2(DEPTH)+1:2]`.
- MMIO is selected when `dAddr[31:16] == MMIO_HI`. The register is chosen by `dAddr[15:2]`.
- Any other address: loads return 0, stores are ignored.

**MMIO registers** (offsets within the window)
- 0x0 TX_DATA: a store pushes `dataOut` into the FIFO. A load returns 0.
- 0x4 TX_STATUS: read-only.
  - bit0 = full.
  - bit1 = empty.
  - bits[15:8] = occupancy count.
  - All other bits 0.
- 0x8 CYCLE: read-only 32-bit cycle counter (see Configuration).
- 0xC DROP_CNT: number of pushes dropped because the FIFO was full.
  - Saturates at 32'hFFFF_FFFF.
  - Any store to this offset clears it to 0.
- Other offsets: loads return 0, stores are ignored.

**FIFO**
- A pop happens when `tx_valid && tx_ready` at the edge.
- Push when not full: the word is accepted.
- Push when full with no pop in the same cycle: the word is dropped and DROP_CNT increments.
- Push and pop in the same cycle:
  - Both take effect, including when the FIFO is full.
  - Count is unchanged; the pushed word is never dropped.
- Pop when empty: not possible, since `tx_valid` is 0.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- `tx_valid` is `!empty`. `tx_data` is the head entry and holds stable while `tx_valid && !tx_ready`.

**Reset values**
- FIFO empty.
- `tx_valid` = 0, `tx_data` = 0.
- DROP_CNT = 0, CYCLE = 0.
- RAM contents are not reset.
- `dataIn` follows the decode of `dAddr`.
- Asserting reset mid-stream discards FIFO contents immediately, without waiting for a clock.

## Timing

- **Loads:** zero latency. `dataIn` is valid in the same cycle as `dAddr`, as the single-cycle CPU requires.
- **Stores:** commit at the rising edge where `DRAMwe` = 1.
  - A load of the same address in that same cycle returns the old value.
  - A load in the next cycle returns the new value.
- **TX_STATUS:** reflects state before the current edge. A push in cycle N shows in the count from cycle N+1.
- **Stream latency:** `tx_valid` rises in the cycle after the first accepted push, i.e. one cycle from store to stream.
- **CYCLE:**
  - Reads 0 in the first cycle after reset deassertion.
  - Then increments by 1 every cycle.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Stores to it are ignored.

## Configuration

- Macro: `DMEM_CYCLE_COUNTER_EN`.
- Defined: the CYCLE register is implemented as described above.
- Undefined:
  - No counter flops are built.
  - Offset 0x8 reads 0 and ignores stores.
  - All other behaviour is identical.

## Structure

- Package `dmem_pkg` holds:
  - the MMIO offset constants (`TX_DATA_OFS`, `TX_STATUS_OFS`, `CYCLE_OFS`, `DROP_CNT_OFS`);
  - the status bit positions (`ST_FULL`, `ST_EMPTY`, `ST_COUNT_LSB`).
- One sub-module, `tx_fifo`: a parameterised synchronous FIFO.
  - Interface: push/pop, full/empty/count, head data.
  - The top level holds the RAM array, the decode, DROP_CNT and CYCLE.

## Test plan

- **Store/load:** store 32'hDEADBEEF to 0x10, load 0x10 in the next cycle → 32'hDEADBEEF. A same-cycle load returns the prior value.
- **Unmapped:** store to 0x8000_0000, then load it → 0. RAM is unchanged.
- **FIFO order and status:** with `tx_ready` = 0, push 1, 2, 3 to 0xFFFF0000 → TX_STATUS = 32'h0000_0300. Raise `tx_ready` → stream emits 1, 2, 3 on consecutive cycles, then `tx_valid` = 0 and TX_STATUS = 32'h2.
- **Overflow:**
  - With `tx_ready` = 0, push 10 words with `FIFO_DEPTH` = 8 → DROP_CNT = 2, TX_STATUS full bit set, stream later emits the first 8 words only.
  - Store to 0xFFFF000C → DROP_CNT = 0.
- **Push with pop at full:** with the FIFO full, push while `tx_ready` = 1 → count stays 8, DROP_CNT unchanged, the new word appears last.
- **Reset and counter:**
  - Assert reset mid-stream → `tx_valid` drops without a clock edge.
  - After release, CYCLE reads 0 and then 5 five cycles later (macro defined); reads 0 with the macro undefined.
